// File: rtl/coin_return_controller_pkg.sv
// rtl/coin_return_controller_pkg.sv - shared sizes and state encoding for the coin return controller
package coin_return_controller_pkg;

    localparam int kNumCoins   = 3;
    localparam int kNumItems   = 4;
    localparam int kTotalBits  = 31;
    localparam int kWaitCycles = 100;

    // Encoding 3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_RETURN = 2'd2
    } state_e;

endpackage

// File: rtl/coin_return_controller_largest_coin_select.sv
// rtl/coin_return_controller_largest_coin_select.sv - greedy picker of the largest coin not exceeding the balance
module largest_coin_select #(
    parameter int kNumCoins  = 3,
    parameter int kTotalBits = 31
) (
    input  logic [kTotalBits-1:0]   balance,
    input  logic [32*kNumCoins-1:0] coin_value,
    output logic [kNumCoins-1:0]    coin,
    output logic                    none
);

    // Denominations ascend, so the last fitting index in the scan is the largest coin.
    always_comb begin
        coin = '0;
        none = 1'b1;
        for (int i = 0; i < kNumCoins; i++) begin
            if (coin_value[32*i +: kTotalBits] <= balance) begin
                coin    = '0;
                coin[i] = 1'b1;
                none    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/coin_return_controller.sv
// rtl/coin_return_controller.sv - idle/count/return controller with inactivity timeout and greedy coin drain
module coin_return_controller #(
    parameter int kNumCoins   = coin_return_controller_pkg::kNumCoins,
    parameter int kTotalBits  = coin_return_controller_pkg::kTotalBits,
    parameter int kWaitCycles = coin_return_controller_pkg::kWaitCycles
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [kTotalBits-1:0]                       current_total,
    input  logic [32*kNumCoins-1:0]                     coin_value,
    input  logic [kNumCoins-1:0]                        i_input_coin,
    input  logic [coin_return_controller_pkg::kNumItems-1:0] o_output_item,
    input  logic                                        i_trigger_return,
    output logic [kNumCoins-1:0]                        o_return_coin,
    output logic [31:0]                                 o_wait_time,
    output logic                                        o_busy
);

    import coin_return_controller_pkg::*;

    localparam logic [31:0] kWaitInit = 32'(kWaitCycles);

    state_e                 state_q, state_d;
    logic [31:0]            wait_q, wait_d;
    logic                   busy_q, busy_d;
    logic [kNumCoins-1:0]   sel_coin;
    logic                   sel_none;
    logic                   activity;
    logic                   total_zero;

    largest_coin_select #(
        .kNumCoins  (kNumCoins),
        .kTotalBits (kTotalBits)
    ) u_select (
        .balance    (current_total),
        .coin_value (coin_value),
        .coin       (sel_coin),
        .none       (sel_none)
    );

    assign activity   = (|i_input_coin) || (|o_output_item);
    assign total_zero = (current_total == '0);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                wait_d = kWaitInit;
                if (!total_zero) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (activity) begin
                    wait_d = kWaitInit;
                end else if (wait_q != 32'd0) begin
                    wait_d = wait_q - 32'd1;
                end
                // An empty balance outranks both the trigger and the timeout.
                if (total_zero) begin
                    state_d = ST_IDLE;
                    wait_d  = kWaitInit;
                end else if (i_trigger_return) begin
                    state_d = ST_RETURN;
                end else if ((wait_q == 32'd0) && !activity) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (sel_none) begin
                    state_d = ST_IDLE;
                    wait_d  = kWaitInit;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = kWaitInit;
            end
        endcase
        busy_d = (state_d == ST_RETURN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wait_q  <= kWaitInit;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
        end
    end

    assign o_return_coin = (state_q == ST_RETURN) ? sel_coin : '0;
    assign o_wait_time   = wait_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_coin_return_controller.sv
// tb/tb_coin_return_controller.sv - directed and table-driven bench for coin_return_controller
module tb_coin_return_controller;

    localparam int kItems = coin_return_controller_pkg::kNumItems;

    logic          clk = 1'b0;
    logic          reset;
    logic [30:0]   current_total;
    logic [95:0]   coin_value;
    logic [2:0]    i_input_coin;
    logic [kItems-1:0] o_output_item;
    logic          i_trigger_return;
    logic [2:0]    o_return_coin;
    logic [31:0]   o_wait_time;
    logic          o_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [30:0] total;
        logic [2:0]  coin;
    } vec_t;
    vec_t vecs[9];

    coin_return_controller #(
        .kNumCoins   (3),
        .kTotalBits  (31),
        .kWaitCycles (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .current_total    (current_total),
        .coin_value       (coin_value),
        .i_input_coin     (i_input_coin),
        .o_output_item    (o_output_item),
        .i_trigger_return (i_trigger_return),
        .o_return_coin    (o_return_coin),
        .o_wait_time      (o_wait_time),
        .o_busy           (o_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [30:0] val(input logic [2:0] c);
        logic [30:0] s;
        s = 31'd0;
        if (c[0]) s = s + 31'd100;
        if (c[1]) s = s + 31'd500;
        if (c[2]) s = s + 31'd1000;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] st();
        return {30'd0, dut.state_q};
    endfunction

    // One edge with the external total register modelled: total += inserted - returned.
    task automatic tick();
        logic [30:0] nxt;
        nxt = current_total + val(i_input_coin) - val(o_return_coin);
        @(posedge clk);
        #1;
        current_total    = nxt;
        i_input_coin     = '0;
        o_output_item    = '0;
        i_trigger_return = 1'b0;
        #1;
    endtask

    initial begin
        int exp_wait[11];
        vecs[0] = '{31'd1000, 3'b100};
        vecs[1] = '{31'd999,  3'b010};
        vecs[2] = '{31'd500,  3'b010};
        vecs[3] = '{31'd499,  3'b001};
        vecs[4] = '{31'd100,  3'b001};
        vecs[5] = '{31'd1600, 3'b100};
        vecs[6] = '{31'h7fff_ffff, 3'b100};
        vecs[7] = '{31'd150,  3'b001};
        vecs[8] = '{31'd99,   3'b000};
        exp_wait = '{4, 4, 3, 4, 3, 2, 4, 3, 2, 1, 0};

        // Bit 31 of the smallest coin is set to confirm only the low kTotalBits are compared.
        coin_value       = {32'd1000, 32'd500, 32'h8000_0064};
        reset            = 1'b1;
        current_total    = '0;
        i_input_coin     = '0;
        o_output_item    = '0;
        i_trigger_return = 1'b0;
        tick();
        tick();
        chk("reset_state", st(), 0);
        chk("reset_wait", o_wait_time, 4);
        chk("reset_busy", {31'd0, o_busy}, 0);
        chk("reset_coin", {29'd0, o_return_coin}, 0);
        reset = 1'b0;

        // Trigger with an empty balance is ignored.
        i_trigger_return = 1'b1;
        tick();
        chk("zero_trig_state", st(), 0);
        chk("zero_trig_busy", {31'd0, o_busy}, 0);
        chk("zero_trig_coin", {29'd0, o_return_coin}, 0);
        tick();
        chk("zero_trig_wait", o_wait_time, 4);

        // Build 1600, then trigger together with activity: trigger wins.
        i_input_coin = 3'b100; tick();
        i_input_coin = 3'b010; tick();
        i_input_coin = 3'b001; tick();
        chk("b_count_state", st(), 1);
        chk("b_total", {1'b0, current_total}, 1600);
        i_trigger_return = 1'b1;
        o_output_item    = 4'b0001;
        tick();
        chk("b_busy", {31'd0, o_busy}, 1);
        chk("b_coin0", {29'd0, o_return_coin}, 3'b100);
        tick();
        chk("b_coin1", {29'd0, o_return_coin}, 3'b010);
        tick();
        chk("b_coin2", {29'd0, o_return_coin}, 3'b001);
        tick();
        chk("b_zero_coin", {29'd0, o_return_coin}, 0);
        chk("b_zero_busy", {31'd0, o_busy}, 1);
        chk("b_zero_total", {1'b0, current_total}, 0);
        tick();
        chk("b_idle_state", st(), 0);
        chk("b_idle_busy", {31'd0, o_busy}, 0);

        // Timeout: activity at edge t, RETURN exactly after t+5.
        i_input_coin = 3'b010; tick();
        tick();
        chk("c_count_state", st(), 1);
        o_output_item = 4'b0010;
        tick();
        chk("c_wait_reload", o_wait_time, 4);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("c_wait_dec", o_wait_time, 32'(4 - k));
            chk("c_not_busy", {31'd0, o_busy}, 0);
        end
        tick();
        chk("c_timeout_busy", {31'd0, o_busy}, 1);
        chk("c_timeout_coin", {29'd0, o_return_coin}, 3'b010);
        tick();
        chk("c_zero_coin", {29'd0, o_return_coin}, 0);
        tick();
        chk("c_idle_state", st(), 0);

        // Coins at edges 0, 3, 6 reload the countdown; no RETURN before edge 11.
        for (int e = 0; e <= 10; e++) begin
            if (e == 0 || e == 3 || e == 6) i_input_coin = 3'b001;
            tick();
            chk("d_wait", o_wait_time, 32'(exp_wait[e]));
            chk("d_not_busy", {31'd0, o_busy}, 0);
        end
        tick();
        chk("d_busy_at_11", {31'd0, o_busy}, 1);
        chk("d_coin_at_11", {29'd0, o_return_coin}, 3'b001);
        tick();
        tick();
        tick();
        chk("d_drained_total", {1'b0, current_total}, 0);
        chk("d_drained_coin", {29'd0, o_return_coin}, 0);
        tick();
        chk("d_idle_state", st(), 0);

        // Reset during RETURN aborts the drain.
        i_input_coin = 3'b100; tick();
        i_input_coin = 3'b100; tick();
        i_input_coin = 3'b001; tick();
        i_trigger_return = 1'b1;
        tick();
        chk("e_first_coin", {29'd0, o_return_coin}, 3'b100);
        tick();
        chk("e_second_coin", {29'd0, o_return_coin}, 3'b100);
        reset = 1'b1;
        tick();
        chk("e_reset_state", st(), 0);
        chk("e_reset_coin", {29'd0, o_return_coin}, 0);
        chk("e_reset_wait", o_wait_time, 4);
        chk("e_reset_busy", {31'd0, o_busy}, 0);
        current_total = '0;
        tick();
        reset = 1'b0;

        // Stranded residual below the smallest coin.
        current_total = 31'd50;
        tick();
        chk("f_count_state", st(), 1);
        i_trigger_return = 1'b1;
        tick();
        chk("f_busy", {31'd0, o_busy}, 1);
        chk("f_no_coin", {29'd0, o_return_coin}, 0);
        tick();
        chk("f_idle_state", st(), 0);
        chk("f_idle_busy", {31'd0, o_busy}, 0);
        chk("f_residual", {1'b0, current_total}, 50);
        tick();
        chk("f_recount_state", st(), 1);
        // Zero balance and trigger together in COUNT go to IDLE.
        current_total    = '0;
        i_trigger_return = 1'b1;
        tick();
        chk("f_zero_trig_state", st(), 0);
        chk("f_zero_trig_busy", {31'd0, o_busy}, 0);

        // Greedy selection table, driven straight onto the balance while in RETURN.
        current_total = 31'd1000;
        tick();
        i_trigger_return = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            current_total = vecs[i].total;
            #1;
            chk("t_coin", {29'd0, o_return_coin}, {29'd0, vecs[i].coin});
            chk("t_busy", {31'd0, o_busy}, 1);
            @(posedge clk);
            #1;
        end
        chk("t_exit_state", st(), 0);
        current_total = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
